par2ser: RTL
============

PAR2SER -- requirements
Module: par2ser

Interface
REQ-001 Parameter: MSB_FIRST, default 1, bit order on dout; 1 = bit 7 first, 0 = bit 0 first.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 din  input  8  parallel byte to transmit.
REQ-005 vldin  input  1  din valid; byte accepted on a rising edge where vldin=1 and rdy=1.
REQ-006 rdy  output  1  holding register empty, can accept a byte.
REQ-007 dout  output  1  serial data bit, registered.
REQ-008 vldout  output  1  high in every cycle where dout carries a frame bit, registered.
REQ-009 sof  output  1  one-cycle pulse coincident with the first bit of each frame, registered.

Function
REQ-010 Datapath SHALL be a 1-entry holding register (hold) feeding an 8-bit shift register (shifter) with a bit counter; states IDLE (shifter empty) and SHIFT.
REQ-011 rdy SHALL be registered and equal to NOT hold_full; vldin while rdy=0 is ignored and the source holds din/vldin.
REQ-012 Accepted byte SHALL be written to hold at the accepting edge; din is not sampled at any other time.
REQ-013 Transfer hold->shifter SHALL occur at an edge where hold_full=1 and either state=IDLE or the shifter is presenting the last bit of its frame.
REQ-014 Latency: byte accepted at edge k with shifter IDLE -> first bit on dout with sof=1, vldout=1 after edge k+1; remaining bits on the following 7 consecutive cycles.
REQ-015 Back-to-back: if hold_full when the last bit is presented, the next frame's first bit SHALL follow at the next edge with no idle cycle (continuous stream, sof on each frame start).
REQ-016 Sustained throughput SHALL be one byte per 8 cycles (9 with parity) when vldin is held high.
REQ-017 When the last bit completes and hold is empty, the block SHALL enter IDLE: dout=0, vldout=0, sof=0.
REQ-018 A transfer and a new acceptance at the same edge are impossible by construction (rdy=0 while hold_full); a new byte may be accepted at the edge following the transfer.
REQ-019 Bit counter SHALL wrap from frame length-1 to 0 on frame end; no other wrap states.

Reset
REQ-020 With rst_n=0 at a rising edge: rdy=1 (first cycle after reset), dout=0, vldout=0, sof=0, hold empty, shifter cleared, counter=0, state=IDLE.
REQ-021 Reset mid-frame or with hold full SHALL discard both the partial frame and the held byte; no bit of either appears after reset release.
REQ-022 vldin during reset SHALL be ignored.

Configuration
REQ-023 Macro PAR2SER_PARITY_EN defined: each frame is 9 bits, 8 data bits then one even-parity bit (XOR of the 8 data bits), vldout high for all 9, sof on the first data bit.
REQ-024 Macro PAR2SER_PARITY_EN undefined: frame is exactly 8 data bits; no parity logic present.

Verification
REQ-025 Single byte: reset, din=8'hA5, vldin for 1 cycle (MSB_FIRST=1) -> after one cycle dout=1,0,1,0,0,1,0,1 over 8 cycles, sof only on first, vldout=1 for 8 cycles then 0.
REQ-026 Streaming: vldin held high with 8'h3C, 8'hFF, 8'h00 -> 24 contiguous valid bits 00111100 11111111 00000000, sof every 8th cycle, rdy deasserts while hold full.
REQ-027 Backpressure: present 8'h81 while rdy=0 -> byte not accepted until rdy=1; exactly one copy transmitted.
REQ-028 Reset mid-frame: send 8'hF0, assert rst_n=0 after 3 bits -> next cycle dout=0, vldout=0, rdy=1; subsequent 8'h0F sends 00001111 only.
REQ-029 MSB_FIRST=0, din=8'h01 -> dout=1,0,0,0,0,0,0,0.
REQ-030 PAR2SER_PARITY_EN defined, din=8'h07 -> 9 bits 00000111 then parity 1; din=8'h03 -> parity 0; back-to-back sof every 9 cycles.

Source files
------------

// File: rtl/par2ser.sv
// Byte-to-serial converter: one holding register feeding an 8-bit shifter.
// Define PAR2SER_PARITY_EN to append an even-parity bit to every frame.
module par2ser #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       vldin,
  output logic       rdy,
  output logic       dout,
  output logic       vldout,
  output logic       sof
);

`ifdef PAR2SER_PARITY_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif
  localparam logic [3:0] LAST = 4'(FLEN - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state, state_d;
  logic [7:0] hold, hold_d, shifter, shifter_d;
  logic       hold_full, hold_full_d;
  logic [3:0] cnt, cnt_d;
  logic       dout_d, vldout_d, sof_d, rdy_d;
`ifdef PAR2SER_PARITY_EN
  logic       par, par_d;
`endif

  logic       accept, last, xfer;
  logic       first_bit, next_bit;
  logic [7:0] load_shift, step_shift;

  // Bit order only changes which end of the shifter drains.
  always_comb begin
    if (MSB_FIRST) begin
      first_bit  = hold[7];
      load_shift = {hold[6:0], 1'b0};
      next_bit   = shifter[7];
      step_shift = {shifter[6:0], 1'b0};
    end else begin
      first_bit  = hold[0];
      load_shift = {1'b0, hold[7:1]};
      next_bit   = shifter[0];
      step_shift = {1'b0, shifter[7:1]};
    end
  end

  assign accept = vldin && rdy;
  assign last   = (state == SHIFT) && (cnt == LAST);
  assign xfer   = hold_full && ((state == IDLE) || last);

  always_comb begin
    state_d     = state;
    hold_d      = hold;
    hold_full_d = hold_full;
    shifter_d   = shifter;
    cnt_d       = cnt;
    dout_d      = dout;
    vldout_d    = vldout;
    sof_d       = 1'b0;
`ifdef PAR2SER_PARITY_EN
    par_d       = par;
`endif

    // rdy is low whenever hold is full, so accept and xfer never coincide.
    if (accept) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end

    if (xfer) begin
      hold_full_d = 1'b0;
      state_d     = SHIFT;
      shifter_d   = load_shift;
      cnt_d       = 4'd0;
      dout_d      = first_bit;
      vldout_d    = 1'b1;
      sof_d       = 1'b1;
`ifdef PAR2SER_PARITY_EN
      par_d       = ^hold;
`endif
    end else begin
      case (state)
        IDLE: begin
          dout_d   = 1'b0;
          vldout_d = 1'b0;
        end
        SHIFT: begin
          if (last) begin
            state_d  = IDLE;
            cnt_d    = 4'd0;
            dout_d   = 1'b0;
            vldout_d = 1'b0;
          end else begin
            cnt_d     = cnt + 4'd1;
            shifter_d = step_shift;
            vldout_d  = 1'b1;
`ifdef PAR2SER_PARITY_EN
            dout_d    = (cnt == 4'd7) ? par : next_bit;
`else
            dout_d    = next_bit;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end

    rdy_d = ~hold_full_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold      <= 8'd0;
      hold_full <= 1'b0;
      shifter   <= 8'd0;
      cnt       <= 4'd0;
      dout      <= 1'b0;
      vldout    <= 1'b0;
      sof       <= 1'b0;
      rdy       <= 1'b1;
`ifdef PAR2SER_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      hold      <= hold_d;
      hold_full <= hold_full_d;
      shifter   <= shifter_d;
      cnt       <= cnt_d;
      dout      <= dout_d;
      vldout    <= vldout_d;
      sof       <= sof_d;
      rdy       <= rdy_d;
`ifdef PAR2SER_PARITY_EN
      par       <= par_d;
`endif
    end
  end

endmodule
